// File: rtl/rvtu_pkg.sv
// Shared RVTU definitions: queue packet ids, multiply function codes, packet layout
// and the client FSM state encoding.
package rvtu_pkg;

  localparam logic [3:0] PID_SRC1 = 4'd11;
  localparam logic [3:0] PID_MUL  = 4'd12;
  localparam logic [3:0] PID_RES  = 4'd0;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_fn_e;

  typedef struct packed {
    logic [3:0]  pid;
    logic [31:0] data;
  } rvtu_pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRC1 = 3'd1,
    ST_OP   = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } mulc_state_e;

  // The op packet id carries the function: 12 + fn, always within 12..15.
  function automatic logic [3:0] op_pid(input mul_fn_e fn);
    return PID_MUL + {2'b00, fn};
  endfunction

endpackage

// File: rtl/rvtu_mul_client.sv
// Core-side front end of the RVTU multiply path: one RV32M multiply in flight,
// sent as {pid,data} packets, result returned with its tag. Option: RVTU_MULC_SRC1_REUSE_EN.
module rvtu_mul_client
  import rvtu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [1:0]       req_fn,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             eg_empty,
  input  logic             eg_deq,
  output logic [35:0]      eg_pkt,
  input  logic             rsp_empty,
  output logic             rsp_deq,
  input  logic [35:0]      rsp_pkt,
  output logic             resp_vld,
  input  logic             resp_rdy,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             err
);

  mulc_state_e      state_q, state_d;
  mul_fn_e          fn_q;
  logic [31:0]      src1_q;
  logic [31:0]      src2_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      resp_data_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic             err_q;
  logic             run_q;
  logic             req_xfer;
  logic             eg_pop;
  logic             reuse_hit;
  rvtu_pkt_t        eg_pkt_s;
  rvtu_pkt_t        rsp_in;

  assign rsp_in   = rvtu_pkt_t'(rsp_pkt);
  assign req_xfer = req_vld & req_rdy;
  assign eg_pop   = eg_deq & ~eg_empty;

  // Responses are drained in every state once out of reset; only WAIT expects one.
  assign rsp_deq  = run_q & ~rsp_empty;

`ifdef RVTU_MULC_SRC1_REUSE_EN
  logic [31:0] src1_cache_q;
  logic        cache_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == ST_SRC1 && eg_pop) begin
      cache_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_SRC1 && eg_pop) begin
      src1_cache_q <= src1_q;
    end
  end

  // The multiply unit keeps the last src1 it received, so a matching operand can be skipped.
  assign reuse_hit = cache_vld_q & (req_src1 == src1_cache_q);
`else
  assign reuse_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_xfer) state_d = reuse_hit ? ST_OP : ST_SRC1;
      ST_SRC1: if (eg_pop) state_d = ST_OP;
      ST_OP:   if (eg_pop) state_d = ST_WAIT;
      ST_WAIT: if (rsp_deq) state_d = ST_RESP;
      ST_RESP: if (resp_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy  = 1'b0;
    eg_empty = 1'b1;
    eg_pkt_s = '0;
    resp_vld = 1'b0;
    unique case (state_q)
      ST_IDLE: req_rdy = 1'b1;
      ST_SRC1: begin
        eg_empty      = 1'b0;
        eg_pkt_s.pid  = PID_SRC1;
        eg_pkt_s.data = src1_q;
      end
      ST_OP: begin
        eg_empty      = 1'b0;
        eg_pkt_s.pid  = op_pid(fn_q);
        eg_pkt_s.data = src2_q;
      end
      ST_RESP: resp_vld = 1'b1;
      default: ;
    endcase
  end

  assign eg_pkt = eg_pkt_s;

  // Operand capture: data only, never reset.
  always_ff @(posedge clk) begin
    if (req_xfer) begin
      fn_q   <= mul_fn_e'(req_fn);
      src1_q <= req_src1;
      src2_q <= req_src2;
      tag_q  <= req_tag;
    end
  end

  // Result capture: held steady through RESP backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else if (state_q == ST_WAIT && rsp_deq) begin
      resp_data_q <= rsp_in.data;
      resp_tag_q  <= tag_q;
    end
  end

  // Sticky: wrong result pid, or any response that was not asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (rsp_deq && (state_q != ST_WAIT || rsp_in.pid != PID_RES)) begin
      err_q <= 1'b1;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_tag  = resp_tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rvtu_mul_client.sv
// Bench for rvtu_mul_client paired with a behavioural multiply unit; table of ops
// plus hand-written backpressure, src1-reuse and reset/stray-response sequences.
module tb_rvtu_mul_client;
  import rvtu_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_vld = 1'b0;
  logic             req_rdy;
  logic [1:0]       req_fn = '0;
  logic [31:0]      req_src1 = '0;
  logic [31:0]      req_src2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             eg_empty;
  logic             eg_deq = 1'b1;
  logic [35:0]      eg_pkt;
  logic             rsp_empty = 1'b1;
  logic             rsp_deq;
  logic [35:0]      rsp_pkt = '0;
  logic             resp_vld;
  logic             resp_rdy = 1'b1;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             err;

  int errors = 0;
  int checks = 0;

  logic [35:0]         eg_log[$];
  logic [35:0]         rq[$];
  logic [TAG_W+31:0]   sb[$];
  logic [31:0]         u_src1 = '0;
  bit                  hold_rsp = 1'b0;
  bit                  bad_pid = 1'b0;
  int                  rsp_pops = 0;

  always #5 clk = ~clk;

  rvtu_mul_client #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_fn(req_fn),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .eg_empty(eg_empty), .eg_deq(eg_deq), .eg_pkt(eg_pkt),
    .rsp_empty(rsp_empty), .rsp_deq(rsp_deq), .rsp_pkt(rsp_pkt),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .resp_tag(resp_tag), .err(err)
  );

  // Reference RV32M multiply on 66-bit signed operands.
  function automatic logic [31:0] mul_ref(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] x, y, p;
    x = (fn == 2'd1 || fn == 2'd2) ? {{34{a[31]}}, a} : {34'b0, a};
    y = (fn == 2'd1) ? {{34{b[31]}}, b} : {34'b0, b};
    p = x * y;
    return (fn == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural multiply unit: keeps src1, answers each op packet with one result.
  always @(posedge clk) begin
    if (rsp_deq && !rsp_empty && rq.size() > 0) begin
      void'(rq.pop_front());
      rsp_pops++;
    end
    if (eg_deq && !eg_empty) begin
      eg_log.push_back(eg_pkt);
      if (eg_pkt[35:32] == 4'd11) u_src1 = eg_pkt[31:0];
      else if (eg_pkt[35:32] >= 4'd12)
        rq.push_back({(bad_pid ? 4'd5 : 4'd0), mul_ref(2'(eg_pkt[35:32] - 4'd12), u_src1, eg_pkt[31:0])});
    end
    rsp_empty <= hold_rsp || (rq.size() == 0);
    rsp_pkt   <= (rq.size() > 0) ? rq[0] : 36'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_eg_empty"}, eg_empty, 1);
    chk({name, "_rsp_deq"}, rsp_deq, 0);
    chk({name, "_resp_vld"}, resp_vld, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_resp_data"}, resp_data, 0);
    chk({name, "_resp_tag"}, resp_tag, 0);
    chk({name, "_req_rdy"}, req_rdy, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = 1'b0;
    eg_deq = 1'b1;
    resp_rdy = 1'b1;
    hold_rsp = 1'b0;
    bad_pid = 1'b0;
    step();
    step();
    chk_reset_outs("rst");
    rq.delete();
    sb.delete();
    eg_log.delete();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic send(input logic [1:0] fn, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    int n = 0;
    while (!req_rdy && n < 50) begin
      step();
      n++;
    end
    chk("send_rdy", req_rdy, 1);
    req_vld = 1'b1;
    req_fn = fn;
    req_src1 = s1;
    req_src2 = s2;
    req_tag = tag;
    step();
    req_vld = 1'b0;
    sb.push_back({tag, exp});
  endtask

  task automatic collect(input string name);
    int n = 0;
    logic [TAG_W+31:0] e;
    while (!resp_vld && n < 50) begin
      step();
      n++;
    end
    chk({name, "_vld"}, resp_vld, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, "_data"}, resp_data, e[31:0]);
      chk({name, "_tag"}, resp_tag, e[TAG_W+31:32]);
    end
    step();
  endtask

  typedef struct {
    logic [1:0]       fn;
    logic [31:0]      s1;
    logic [31:0]      s2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  initial begin
    vec_t vt[8];
    logic [TAG_W+31:0] ea;
    logic [3:0] p;
    int n;

    vt[0] = '{2'd0, 32'h0000_0003, 32'h0000_0005, 5'd7,  32'h0000_000F};
    vt[1] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vt[2] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
    vt[3] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF};
    vt[4] = '{2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd4,  32'h3FFF_FFFF};
    vt[5] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001};
    vt[6] = '{2'd3, 32'h8000_0000, 32'h0000_0002, 5'd6,  32'h0000_0001};
    vt[7] = '{2'd0, 32'h1234_5678, 32'h0000_0010, 5'd31, 32'h2345_6780};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      eg_log.delete();
      send(vt[i].fn, vt[i].s1, vt[i].s2, vt[i].tag, vt[i].exp);
      chk("tbl_first_pkt_vld", eg_empty, 0);
      chk("tbl_first_pkt", eg_pkt, {4'd11, vt[i].s1});
      collect("tbl");
      p = 4'd12 + {2'b00, vt[i].fn};
      chk("tbl_eg_count", eg_log.size(), 2);
      if (eg_log.size() >= 2) begin
        chk("tbl_eg_src1", eg_log[0], {4'd11, vt[i].s1});
        chk("tbl_eg_op", eg_log[1], {p, vt[i].s2});
      end
      chk("tbl_err", err, 0);
    end

    // Egress backpressure while the src1 packet is offered.
    eg_log.delete();
    eg_deq = 1'b0;
    send(2'd0, 32'd7, 32'd9, 5'd3, 32'h3F);
    for (int i = 0; i < 4; i++) begin
      chk("bp_eg_empty", eg_empty, 0);
      chk("bp_eg_pkt", eg_pkt, {4'd11, 32'd7});
      chk("bp_req_rdy", req_rdy, 0);
      step();
    end
    eg_deq = 1'b1;
    collect("bp");
    chk("bp_eg_count", eg_log.size(), 2);

    // Response backpressure with a second request waiting.
    resp_rdy = 1'b0;
    send(2'd3, 32'h8000_0000, 32'd2, 5'd9, 32'd1);
    n = 0;
    while (!resp_vld && n < 50) begin
      step();
      n++;
    end
    ea = sb.pop_front();
    req_vld = 1'b1;
    req_fn = 2'd0;
    req_src1 = 32'd6;
    req_src2 = 32'd7;
    req_tag = 5'd10;
    for (int i = 0; i < 3; i++) begin
      chk("rbp_vld", resp_vld, 1);
      chk("rbp_data", resp_data, ea[31:0]);
      chk("rbp_tag", resp_tag, ea[TAG_W+31:32]);
      chk("rbp_req_rdy", req_rdy, 0);
      step();
    end
    resp_rdy = 1'b1;
    step();
    chk("rbp_done_vld", resp_vld, 0);
    chk("rbp_idle_rdy", req_rdy, 1);
    step();
    req_vld = 1'b0;
    sb.push_back({5'd10, 32'd42});
    chk("rbp_b_accepted", req_rdy, 0);
    collect("rbp_b");

    // Back-to-back ops sharing src1.
    eg_log.delete();
    send(2'd3, 32'h1234, 32'h0010_0000, 5'd11, 32'h1);
    collect("reuse_a");
    eg_log.delete();
    send(2'd3, 32'h1234, 32'h1000_0000, 5'd12, 32'h123);
    collect("reuse_b");
`ifdef RVTU_MULC_SRC1_REUSE_EN
    chk("reuse_eg_count", eg_log.size(), 1);
    if (eg_log.size() >= 1) chk("reuse_eg_op", eg_log[0], {4'd15, 32'h1000_0000});
`else
    chk("reuse_eg_count", eg_log.size(), 2);
    if (eg_log.size() >= 2) begin
      chk("reuse_eg_src1", eg_log[0], {4'd11, 32'h1234});
      chk("reuse_eg_op", eg_log[1], {4'd15, 32'h1000_0000});
    end
`endif

    // Reset while waiting for the result, then a stray late response.
    eg_log.delete();
    hold_rsp = 1'b1;
    send(2'd0, 32'h11, 32'h2, 5'd13, 32'h22);
    n = 0;
    while (eg_log.size() < 2 && n < 50) begin
      step();
      n++;
    end
    chk("mr_reached_wait", eg_log.size(), 2);
    step();
    chk("mr_no_resp", resp_vld, 0);
    rst_n = 1'b0;
    step();
    chk_reset_outs("mr");
    sb.delete();
    rq.delete();
    rst_n = 1'b1;
    step();
    step();
    rsp_pops = 0;
    rq.push_back({4'd0, 32'hAA});
    hold_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("mr_stray_no_resp", resp_vld, 0);
      step();
    end
    chk("mr_stray_popped", rq.size(), 0);
    chk("mr_stray_pops", rsp_pops, 1);
    chk("mr_stray_err", err, 1);
    chk("mr_idle", req_rdy, 1);

    // Result carrying a wrong pid still returns its data and sets err.
    do_reset();
    bad_pid = 1'b1;
    send(2'd0, 32'd2, 32'd3, 5'd14, 32'd6);
    collect("pid");
    chk("pid_err", err, 1);
    bad_pid = 1'b0;
    send(2'd0, 32'd4, 32'd5, 5'd15, 32'd20);
    collect("pid_after");
    chk("pid_err_sticky", err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
